// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-memory access stage: req/ack transaction, byte lanes, strobes, load extension
module mem_access_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CTRL_i_mem_rd,
  input  logic             CTRL_i_mem_wr,
  input  logic [2:0]       CTRL_i_funct3,
  input  logic [WIDTH-1:0] EXU_i_valE,
  input  logic [WIDTH-1:0] REG_i_rs2,
  input  logic             DMEM_i_ack,
  input  logic [WIDTH-1:0] DMEM_i_rdata,
  output logic             DMEM_o_req,
  output logic             DMEM_o_we,
  output logic [WIDTH-1:0] DMEM_o_addr,
  output logic [WIDTH-1:0] DMEM_o_wdata,
  output logic [3:0]       DMEM_o_wstrb,
  output logic [WIDTH-1:0] MEM_o_valM,
  output logic             MEM_o_stall,
  output logic             MEM_o_fault
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nx;
  logic             is_load, is_store, bad_f3, misal, fault_raw, access, accept;
  logic [1:0]       off, off_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] wdata_nx, lane, ld_val;
  logic [3:0]       wstrb_nx;

  // Access decode from the instruction currently presented
  always_comb begin
    is_load   = CTRL_i_mem_rd & ~CTRL_i_mem_wr;
    is_store  = CTRL_i_mem_wr & ~CTRL_i_mem_rd;
    off       = EXU_i_valE[1:0];
    bad_f3    = is_load ? ((CTRL_i_funct3[1:0] == 2'b11) | (CTRL_i_funct3[2] & CTRL_i_funct3[1]))
                        : (CTRL_i_funct3[2] | (CTRL_i_funct3[1:0] == 2'b11));
    misal     = ((CTRL_i_funct3[1:0] == 2'b01) & off[0]) |
                ((CTRL_i_funct3[1:0] == 2'b10) & (off != 2'b00));
    fault_raw = (CTRL_i_mem_rd & CTRL_i_mem_wr) | ((is_load | is_store) & (bad_f3 | misal));
    access    = (CTRL_i_mem_rd ^ CTRL_i_mem_wr) & ~fault_raw;
    accept    = (state == IDLE) & access;
  end

  always_comb begin
    wdata_nx = REG_i_rs2;
    wstrb_nx = 4'b1111;
    case (CTRL_i_funct3[1:0])
      2'b00: begin
        wdata_nx = {4{REG_i_rs2[7:0]}};
        wstrb_nx = 4'b0001 << off;
      end
      2'b01: begin
        wdata_nx = {2{REG_i_rs2[15:0]}};
        wstrb_nx = 4'b0011 << off;
      end
      default: ;
    endcase
    if (!CTRL_i_mem_wr) wstrb_nx = 4'b0000;
  end

  // Lane extraction uses the offset and size latched at acceptance
  always_comb begin
    lane = DMEM_i_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_val = {24'b0, lane[7:0]};
      3'b101:  ld_val = {16'b0, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (access) state_nx = REQ;
      REQ:     if (DMEM_i_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      DMEM_o_we    <= 1'b0;
      DMEM_o_addr  <= '0;
      DMEM_o_wdata <= '0;
      DMEM_o_wstrb <= 4'b0000;
      MEM_o_valM   <= '0;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
    end else begin
      state <= state_nx;
      if (accept) begin
        DMEM_o_we    <= CTRL_i_mem_wr;
        DMEM_o_addr  <= {EXU_i_valE[WIDTH-1:2], 2'b00};
        DMEM_o_wdata <= wdata_nx;
        DMEM_o_wstrb <= wstrb_nx;
        off_q        <= off;
        f3_q         <= CTRL_i_funct3;
      end
      if ((state == REQ) && DMEM_i_ack && !DMEM_o_we) MEM_o_valM <= ld_val;
    end
  end

  assign DMEM_o_req  = (state == REQ);
  assign MEM_o_stall = accept | (state == REQ);
  assign MEM_o_fault = (state == IDLE) & fault_raw;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the single-cycle CPU. It sits between the execute unit, which supplies the effective address in valE, and the write-back mux, which consumes the loaded value as valM. It turns load/store control into a req/ack transaction on the data-memory port. It handles byte lanes, write strobes and sign extension, and stalls the core while a transaction is outstanding.

## Interface
- WIDTH, 32, datapath width; only 32 is supported (4-bit strobe).
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- CTRL_i_mem_rd  in  1  current instruction is a load.
- CTRL_i_mem_wr  in  1  current instruction is a store.
- CTRL_i_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 (stores).
- EXU_i_valE  in  WIDTH  effective byte address.
- REG_i_rs2  in  WIDTH  store data.
- DMEM_i_ack  in  1  memory completes the pending request.
- DMEM_i_rdata  in  WIDTH  read word, valid with ack.
- DMEM_o_req  out  1  request pending.
- DMEM_o_we  out  1  1 = write.
- DMEM_o_addr  out  WIDTH  word-aligned address, {valE[31:2],2'b00}.
- DMEM_o_wdata  out  WIDTH  lane-replicated store data.
- DMEM_o_wstrb  out  4  byte write enables.
- MEM_o_valM  out  WIDTH  extended load result.
- MEM_o_stall  out  1  hold PC/instruction this cycle.
- MEM_o_fault  out  1  misaligned or illegal access; no transaction issued.

## Operation
- FSM states: IDLE, REQ, DONE.
- Access condition: (mem_rd ^ mem_wr) and fault is low.
- fault is combinational and asserts in IDLE only, when any of the following holds:
  - mem_rd and mem_wr are both high;
  - funct3 is illegal for the access (loads: 011, 110, 111; stores: anything other than 000–010);
  - a halfword access has valE[0]=1;
  - a word access has valE[1:0]≠0.
- IDLE → REQ on the access condition. At that edge, register the following and hold them stable until ack:
  - addr, we = mem_wr, and the byte offset valE[1:0];
  - funct3;
  - wdata: sb {4{rs2[7:0]}}, sh {2{rs2[15:0]}}, sw rs2;
  - wstrb: sb 0001<<off, sh 0011<<off, sw 1111. Loads drive wstrb = 0000.
- REQ: req=1. Stay until ack is sampled high, then go to DONE with req=0.
  - For a load, the ack edge also loads valM with the lane extracted from rdata at the latched offset. Zero-extend for bu/hu; sign-extend for b/h; w passes the word unchanged.
- DONE → IDLE unconditionally. This state exists so the still-presented instruction is not re-issued.
- Stores never change valM. valM holds its last value in all other states.
- addr, we, wdata and wstrb hold their values after ack until the next acceptance.
- ack sampled outside REQ is ignored.

## Timing
- Reset values:
  - state IDLE;
  - req=0, we=0, addr=0, wdata=0, wstrb=0, valM=0.
  - Asserting rst mid-REQ drops req immediately, abandons the transaction and leaves valM at 0.
- stall = (IDLE and access condition) or REQ. stall is 0 in DONE and on a fault.
- Cycle 0: IDLE, access seen, stall=1. Cycle 1: req=1.
- Ack seen in cycle k≥1 → DONE in cycle k+1 with stall=0. For a load, valM is valid in that cycle.
- Minimum latency (ack in cycle 1): 2 stall cycles, result in cycle 2.
- Non-memory instruction (rd=wr=0): no stall, no request, valM unchanged.

## Test plan
- Load word, zero wait: valE=0x100, funct3=010, ack and rdata=0xDEADBEEF in cycle 1 → req only in cycle 1, addr=0x100, wstrb=0000, stall high in cycles 0–1, valM=0xDEADBEEF in cycle 2 with stall=0.
- Byte loads, sign and zero: rdata=0x80FF7F01, valE=0x203.
  - lb → valM=0xFFFFFF80.
  - lbu → valM=0x00000080.
  - lh at 0x202 → valM=0xFFFF80FF.
- Store byte/half with 3-cycle wait: sb rs2=0x12345678 at 0x301 → wdata=0x78787878, wstrb=0010, we=1 held stable over 3 cycles until ack. sh at 0x302 → wstrb=1100. valM is unchanged in both cases.
- Faults:
  - lw at 0x102 → fault=1, req never asserts, stall=0.
  - rd=wr=1 → fault=1.
  - load funct3=011 → fault=1.
- Reset mid-REQ: assert rst two cycles into a pending load → req=0 in the same cycle, state IDLE, valM=0. A late ack after reset release is ignored.
- Back-to-back: load then store on consecutive instructions → the DONE cycle does not re-issue the load. The store is accepted in the following IDLE cycle.
